burst_assembler: RTL and testbench
==================================

# burst_assembler

Collects one AXI write burst, an AW address beat followed by up to 8 W data beats, into a single `burst_slot` record from `pkg`. Hands the record to the speculative slot stage with a valid/ready handshake. Sits between the AXI slave write port and the spec-slot/classification logic, which consumes `burst_slot` and routes it using `awuser` (REGULAR/BLOCK/DIVERT/UNLUCKY). The block holds one burst at a time and does not produce a B response.

## Interface
Parameters: all widths come from `pkg`; the block has no local parameters.
- PID_WIDTH, 4: awid width
- PLENGTH_WIDTH, 3: awlen width; maximum burst is 8 beats
- PDATA_WIDTH, 8: W beat width in bytes (64-bit wdata)
- PCOMPLETE_DATA, 72: byte capacity of `burst_slot.data` and `burst_slot.strb`

Ports:
- clk, in, 1: single clock
- rst, in, 1: asynchronous, active-high reset
- awvalid / awready, in / out, 1 / 1: AW handshake
- awid, awlen, awburst, awaddr, awsize, awuser, in: widths 4, 3, 2, 32, 2, 2
- wvalid / wready, in / out, 1 / 1: W handshake
- wdata, in, 64: write data
- wstrb, in, 8: per-byte strobe
- wlast, in, 1: last-beat marker
- out_valid, out, 1: `out_slot` holds a complete burst
- out_ready, in, 1: consumer accepts
- out_slot, out, $bits(burst_slot): assembled record
- proto_err, out, 1: one-cycle pulse when wlast disagrees with the beat count

## Operation
- FSM states: IDLE, DATA, OUT. Reset state is IDLE.
- awready, wready and out_valid are registered decodes of the next state.
- **IDLE**
  - awready=1.
  - On awvalid&awready: latch awid/awlen/awburst/awaddr/awsize/awuser into out_slot; clear all data and strb to 0; beat_cnt=0; go to DATA.
- **DATA**
  - wready=1.
  - On each wvalid&wready, write wdata bytes [k] into data[beat_cnt*8+k] and wstrb[k] into strb[beat_cnt*8+k], for k=0..7.
  - Bytes are placed even when the strobe bit is 0. Lanes are not repacked for narrow awsize.
  - On the beat where beat_cnt==awlen: go to OUT. Otherwise beat_cnt increments.
- **Burst end and errors**
  - The burst always ends on beat awlen+1. wlast does not terminate it.
  - proto_err pulses on the accepted beat when wlast=1 with beat_cnt≠awlen, or when wlast=0 with beat_cnt==awlen.
- **OUT**
  - out_valid=1; out_slot is stable.
  - On out_valid&out_ready: go to IDLE.
- **Capacity and arithmetic**
  - beat_cnt is 3 bits and never wraps; awlen=7 gives beat_cnt 0..7.
  - data bytes 64..71 are always 0, and so are their strb bits.
- **Reset behaviour**
  - W beats arriving in IDLE or OUT are not accepted (wready=0). AW arriving in DATA or OUT is not accepted (awready=0).
  - rst at any time returns to IDLE and discards any partial burst.
  - Reset values: awready=0, wready=0, out_valid=0, proto_err=0, out_slot all zero.

## Timing
- awready rises on the first clk edge after rst deasserts.
- AW handshake at edge N: wready=1 from edge N.
- Last W beat at edge M: out_valid=1 from edge M.
- Output handshake at edge P: awready=1 from edge P.
- Minimum period per burst is awlen+3 cycles. There is one bubble cycle in IDLE; no AW is accepted while OUT drains.
- out_slot changes only on the AW handshake or on W beats. It is constant while out_valid=1.
- proto_err is asserted in the cycle after the offending beat.

## Structure
- Add to `pkg`: `typedef enum logic [1:0] {ASM_IDLE, ASM_DATA, ASM_OUT} asm_state_t;`
- Add to `pkg`: `localparam BEAT_BYTES = PDATA_WIDTH;`
- `burst_slot` is reused unchanged.
- No sub-module: the beat counter and byte-lane write enables are inline.

## Test plan
- **Single beat.** awlen=0, awid=3, awaddr=0x1000, awuser=REGULAR, wdata=0x1122334455667788, wstrb=0xFF, wlast=1. Required: out_slot.data[7:0] bytes = 88,77..11; strb[7:0]=0xFF; all other bytes and strb 0; awid=3; out_valid 1 cycle after the beat; no proto_err.
- **Full burst with stalls.** awlen=7; beats carry wdata = beat index replicated; wvalid toggles; out_ready is held 0 for 5 cycles. Required: data[i*8+:8] = i for all bytes of beat i; strb[63:0]=all 1; bytes 64..71 = 0; out_slot stable during the stall; awready=0 until the out handshake.
- **Early wlast.** awlen=3, wlast=1 on beat 1. Required: proto_err pulse after beat 1; the burst still collects 4 beats.
- **Missing wlast.** Same burst with wlast=0 on beat 3. Required: proto_err pulse after beat 3; out_valid asserted.
- **Back-to-back bursts.** awvalid is held high with a second AW (awid=5, awuser=DIVERT). Required: the second AW is accepted exactly 1 cycle after the first out handshake; the second record has zeroed data beyond its own awlen.
- **Mid-burst reset.** rst asserted after beat 2 of a 6-beat burst. Required: immediately awready=0, wready=0, out_valid=0, out_slot=0; after release, a new single-beat burst completes correctly.

Source files
------------

// File: rtl/burst_assembler_pkg.sv
// Shared widths, AXI user codes, the assembled burst record and the assembler state type.
package burst_assembler_pkg;

    localparam int PID_WIDTH      = 4;
    localparam int PLENGTH_WIDTH  = 3;
    localparam int PDATA_WIDTH    = 8;
    localparam int PCOMPLETE_DATA = 72;
    localparam int PADDR_WIDTH    = 32;
    localparam int PBURST_WIDTH   = 2;
    localparam int PSIZE_WIDTH    = 2;
    localparam int PUSER_WIDTH    = 2;

    localparam BEAT_BYTES = PDATA_WIDTH;
    localparam int SLOT_IDX_W = $clog2(PCOMPLETE_DATA);

    typedef enum logic [PUSER_WIDTH-1:0] {REGULAR, BLOCK, DIVERT, UNLUCKY} awuser_t;

    typedef struct packed {
        logic [PID_WIDTH-1:0]                awid;
        logic [PLENGTH_WIDTH-1:0]            awlen;
        logic [PBURST_WIDTH-1:0]             awburst;
        logic [PADDR_WIDTH-1:0]              awaddr;
        logic [PSIZE_WIDTH-1:0]              awsize;
        awuser_t                             awuser;
        logic [PCOMPLETE_DATA-1:0][7:0]      data;
        logic [PCOMPLETE_DATA-1:0]           strb;
    } burst_slot;

    typedef enum logic [1:0] {ASM_IDLE, ASM_DATA, ASM_OUT} asm_state_t;

endpackage

// File: rtl/burst_assembler.sv
// Collects one AXI AW beat plus up to 8 W beats into a burst_slot record and
// offers it downstream with a valid/ready handshake; one burst in flight.
module burst_assembler
    import burst_assembler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [PID_WIDTH-1:0]       awid,
    input  logic [PLENGTH_WIDTH-1:0]   awlen,
    input  logic [PBURST_WIDTH-1:0]    awburst,
    input  logic [PADDR_WIDTH-1:0]     awaddr,
    input  logic [PSIZE_WIDTH-1:0]     awsize,
    input  logic [PUSER_WIDTH-1:0]     awuser,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [PDATA_WIDTH*8-1:0]   wdata,
    input  logic [PDATA_WIDTH-1:0]     wstrb,
    input  logic                       wlast,
    output logic                       out_valid,
    input  logic                       out_ready,
    output burst_slot                  out_slot,
    output logic                       proto_err
);

    asm_state_t                 r_state;
    asm_state_t                 w_next;
    logic                       r_awready;
    logic                       r_wready;
    logic                       r_out_valid;
    logic                       r_proto_err;
    logic [PLENGTH_WIDTH-1:0]   r_beat_cnt;
    burst_slot                  r_slot;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_out_hs;
    logic                       w_last_beat;
    logic [SLOT_IDX_W-1:0]      w_base;

    assign w_aw_hs     = awvalid & r_awready;
    assign w_w_hs      = wvalid & r_wready;
    assign w_out_hs    = r_out_valid & out_ready;
    assign w_last_beat = (r_beat_cnt == r_slot.awlen);
    assign w_base      = SLOT_IDX_W'(r_beat_cnt) * SLOT_IDX_W'(BEAT_BYTES);

    // Burst length comes from awlen alone; wlast only feeds the protocol check.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ASM_IDLE: if (w_aw_hs) w_next = ASM_DATA;
            ASM_DATA: if (w_w_hs && w_last_beat) w_next = ASM_OUT;
            ASM_OUT:  if (w_out_hs) w_next = ASM_IDLE;
            default:  w_next = ASM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ASM_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_out_valid <= 1'b0;
            r_proto_err <= 1'b0;
            r_beat_cnt  <= '0;
            r_slot      <= '0;
        end else begin
            r_state     <= w_next;
            r_awready   <= (w_next == ASM_IDLE);
            r_wready    <= (w_next == ASM_DATA);
            r_out_valid <= (w_next == ASM_OUT);
            r_proto_err <= w_w_hs && (wlast != w_last_beat);

            if (w_aw_hs) begin
                r_slot.awid    <= awid;
                r_slot.awlen   <= awlen;
                r_slot.awburst <= awburst;
                r_slot.awaddr  <= awaddr;
                r_slot.awsize  <= awsize;
                r_slot.awuser  <= awuser_t'(awuser);
                r_slot.data    <= '0;
                r_slot.strb    <= '0;
                r_beat_cnt     <= '0;
            end else if (w_w_hs) begin
                // Full-lane placement: disabled strobes still deposit their byte.
                r_slot.data[w_base +: BEAT_BYTES] <= wdata;
                r_slot.strb[w_base +: BEAT_BYTES] <= wstrb;
                if (!w_last_beat)
                    r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign awready   = r_awready;
    assign wready    = r_wready;
    assign out_valid = r_out_valid;
    assign out_slot  = r_slot;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_burst_assembler.sv
// Directed bench for burst_assembler: expected records are queued as beats are
// driven and compared when the assembler presents them.
module tb_burst_assembler;
    import burst_assembler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [2:0]  awlen;
    logic [1:0]  awburst;
    logic [31:0] awaddr;
    logic [1:0]  awsize;
    logic [1:0]  awuser;
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        out_valid;
    logic        out_ready;
    burst_slot   out_slot;
    logic        proto_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    burst_slot   exp_q[$];
    burst_slot   cur;
    burst_slot   held;
    int          n_aw;

    burst_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .awvalid   (awvalid),
        .awready   (awready),
        .awid      (awid),
        .awlen     (awlen),
        .awburst   (awburst),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .awuser    (awuser),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slot  (out_slot),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives an AW beat until accepted; reports edges taken and seeds the model record.
    task automatic do_aw(input logic [3:0] id, input logic [2:0] len, input logic [31:0] addr,
                         input logic [1:0] user, output int cycles);
        logic hs;
        cycles  = 0;
        awvalid = 1'b1; awid = id; awlen = len; awburst = 2'd1;
        awaddr  = addr; awsize = 2'd3; awuser = user;
        do begin
            hs = awready;
            tick();
            cycles++;
        end while (!hs && cycles < 20);
        chk("aw_accept", hs, 1'b1);
        awvalid = 1'b0;
        cur = '0;
        cur.awid = id; cur.awlen = len; cur.awburst = 2'd1;
        cur.awaddr = addr; cur.awsize = 2'd3; cur.awuser = awuser_t'(user);
        chk("aw_wready_on", wready, 1'b1);
        chk("aw_awready_off", awready, 1'b0);
    endtask

    task automatic send_beat(input int idx, input int len, input logic [63:0] d,
                             input logic [7:0] s, input logic last);
        logic hs;
        int   n = 0;
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
        do begin
            hs = wready;
            tick();
            n++;
        end while (!hs && n < 20);
        chk("w_accept", hs, 1'b1);
        wvalid = 1'b0; wlast = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cur.data[idx*8 + k] = d[k*8 +: 8];
            cur.strb[idx*8 + k] = s[k];
        end
        chk($sformatf("proto_err_b%0d", idx), proto_err, last != (idx == len));
        if (idx == len) begin
            exp_q.push_back(cur);
            chk("ovalid_after_last", out_valid, 1'b1);
        end else begin
            chk("ovalid_mid", out_valid, 1'b0);
        end
    endtask

    task automatic collect(input string tag);
        burst_slot e;
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_hdr"},
                {out_slot.awid, out_slot.awlen, out_slot.awburst, out_slot.awaddr, out_slot.awsize, out_slot.awuser},
                {e.awid, e.awlen, e.awburst, e.awaddr, e.awsize, e.awuser});
            chk({tag, "_data"}, out_slot.data, e.data);
            chk({tag, "_strb"}, out_slot.strb, e.strb);
        end
        tick();
        chk({tag, "_awready_after"}, awready, 1'b1);
        chk({tag, "_ovalid_after"}, out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; awvalid = 1'b0; awid = '0; awlen = '0; awburst = '0; awaddr = '0;
        awsize = '0; awuser = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        out_ready = 1'b0;

        // Reset values and first-edge awready.
        #1;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_perr", proto_err, 1'b0);
        chk("rst_slot_data", out_slot.data, '0);
        tick(); tick();
        rst = 1'b0;
        chk("rel_awready_pre", awready, 1'b0);
        tick();
        chk("rel_awready_post", awready, 1'b1);
        chk("idle_wready", wready, 1'b0);

        // Single beat.
        do_aw(4'd3, 3'd0, 32'h1000, 2'(REGULAR), n_aw);
        send_beat(0, 0, 64'h1122334455667788, 8'hFF, 1'b1);
        chk("single_byte0", out_slot.data[0], 8'h88);
        chk("single_byte7", out_slot.data[7], 8'h11);
        chk("single_byte8", out_slot.data[8], 8'h00);
        chk("single_awid", out_slot.awid, 4'd3);
        collect("single");

        // Full burst, toggling wvalid, stalled consumer with stray W traffic.
        do_aw(4'd9, 3'd7, 32'h2000, 2'(BLOCK), n_aw);
        for (int i = 0; i < 8; i++) begin
            send_beat(i, 7, {8{8'(i)}}, 8'hFF, i == 7);
            if (i != 7) begin
                tick();
                chk("toggle_perr_idle", proto_err, 1'b0);
            end
        end
        held = exp_q[0];
        wvalid = 1'b1; wstrb = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            wdata = {$urandom, $urandom};
            tick();
            chk("stall_slot_data", out_slot.data, held.data);
            chk("stall_awready", awready, 1'b0);
            chk("stall_wready", wready, 1'b0);
            chk("stall_ovalid", out_valid, 1'b1);
        end
        wvalid = 1'b0;
        chk("full_strb_all", out_slot.strb, {8'h00, 64'hFFFF_FFFF_FFFF_FFFF});
        chk("full_tail_zero", out_slot.data[71:64], '0);
        collect("full");

        // Early wlast on beat 1; burst still runs to 4 beats.
        do_aw(4'd1, 3'd3, 32'h3000, 2'(REGULAR), n_aw);
        send_beat(0, 3, 64'hA0A1A2A3A4A5A6A7, 8'h0F, 1'b0);
        send_beat(1, 3, 64'hB0B1B2B3B4B5B6B7, 8'hF0, 1'b1);
        send_beat(2, 3, 64'hC0C1C2C3C4C5C6C7, 8'h00, 1'b0);
        send_beat(3, 3, 64'hD0D1D2D3D4D5D6D7, 8'h81, 1'b1);
        collect("early");

        // Missing wlast on the final beat.
        do_aw(4'd2, 3'd3, 32'h3100, 2'(UNLUCKY), n_aw);
        for (int i = 0; i < 4; i++)
            send_beat(i, 3, {$urandom, $urandom}, 8'(8'h11 << i), 1'b0);
        collect("missing");

        // Back-to-back: second AW held during the first output handshake.
        do_aw(4'd4, 3'd1, 32'h4000, 2'(REGULAR), n_aw);
        send_beat(0, 1, 64'h0102030405060708, 8'hFF, 1'b0);
        send_beat(1, 1, 64'h1112131415161718, 8'hFF, 1'b1);
        awvalid = 1'b1; awid = 4'd5; awlen = 3'd2; awaddr = 32'h5000; awuser = 2'(DIVERT);
        tick();
        chk("b2b_awready_in_out", awready, 1'b0);
        collect("b2b_first");
        do_aw(4'd5, 3'd2, 32'h5000, 2'(DIVERT), n_aw);
        chk("b2b_aw_latency", n_aw, 1);
        for (int i = 0; i < 3; i++)
            send_beat(i, 2, {$urandom, $urandom}, 8'hFF, i == 2);
        collect("b2b_second");

        // Mid-burst reset after beat 2 of a 6-beat burst.
        do_aw(4'd6, 3'd5, 32'h6000, 2'(BLOCK), n_aw);
        for (int i = 0; i < 3; i++)
            send_beat(i, 5, {$urandom, $urandom}, 8'hFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_awready", awready, 1'b0);
        chk("mrst_wready", wready, 1'b0);
        chk("mrst_ovalid", out_valid, 1'b0);
        chk("mrst_slot_data", out_slot.data, '0);
        chk("mrst_slot_hdr", {out_slot.awid, out_slot.awaddr}, '0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_rel_awready", awready, 1'b1);
        do_aw(4'd7, 3'd0, 32'h7000, 2'(REGULAR), n_aw);
        send_beat(0, 0, 64'hCAFEBABEDEADBEEF, 8'h5A, 1'b1);
        collect("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
